// File: rtl/opti_pkg.sv
// rtl/opti_pkg.sv - shared widths and FSM encoding for the IIR sample feeder
package opti_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 11;
  localparam int TMO_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FETCH,
    ST_SEND,
    ST_GAP,
    ST_WAIT_DONE,
    ST_FIN
  } state_e;

endpackage

// File: rtl/opti_sample_ram.sv
// rtl/opti_sample_ram.sv - simple dual-port sample RAM, one write port, registered read
module opti_sample_ram
  import opti_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int AW    = ADDR_W,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/opti_feeder.sv
// rtl/opti_feeder.sv - loads host samples and streams them into the filter at fixed pacing
module opti_feeder
  import opti_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int GAP     = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              go,
  output logic              start,
  output logic [DATA_W-1:0] data_in,
  output logic              data_in_valid,
  input  logic              filter_done,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] GAP_LAST = TMO_W'(GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   sent_cnt_q, sent_cnt_d;
  logic [TMO_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic [ADDR_W:0]   num_clamped;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign num_clamped = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;

  opti_sample_ram #(
    .DW    (DATA_W),
    .AW    (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (sent_cnt_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      sent_cnt_q <= '0;
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sent_cnt_q <= sent_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sent_cnt_d = sent_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          count_d    = num_clamped;
          sent_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = (num_clamped == '0) ? ST_FIN : ST_START;
        end
      end
      ST_START: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        sent_cnt_d = sent_cnt_q + CNT_ONE;
        gap_cnt_d  = '0;
        wait_cnt_d = '0;
        state_d    = ((sent_cnt_q + CNT_ONE) == count_q) ? ST_WAIT_DONE : ST_GAP;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + TMO_ONE;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_DONE: begin
        // A completion arriving on the final allowed cycle wins over the timeout.
        wait_cnt_d = wait_cnt_q + TMO_ONE;
        if (filter_done) begin
          state_d = ST_FIN;
        end else if (wait_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start         = (state_q == ST_START);
    data_in_valid = (state_q == ST_SEND);
    data_in       = (state_q == ST_SEND) ? ram_rdata : '0;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_FIN);
    timeout       = timeout_q;
    sent_cnt      = sent_cnt_q;
    ram_we        = wr_en && (state_q == ST_IDLE);
    // Next read is launched one cycle ahead of SEND so the RAM output lines up.
    ram_re        = (state_q == ST_FETCH) ||
                    ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST));
  end

endmodule
